// File: rtl/vga_pkg.sv
// vga_pkg: shared framebuffer geometry, bus widths and scan states
package vga_pkg;
  localparam int H_ACTIVE_DFLT = 640;
  localparam int V_ACTIVE_DFLT = 480;
  localparam int ADDR_W = 19;
  localparam int PIX_W = 24;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
endpackage

// File: rtl/vga_pix_fifo.sv
// vga_pix_fifo: show-ahead pixel FIFO; an incoming word falls through to the head when empty
module vga_pix_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic                   valid,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic empty;
  assign empty = count == '0;
  assign valid = !empty || push;
  assign dout = !empty ? mem[rp] : push ? din : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else if (flush) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the single-port framebuffer between raster-order display refill and CPU access
module vga_fb_arbiter import vga_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DFLT,
  parameter int V_ACTIVE = V_ACTIVE_DFLT,
  parameter int FIFO_DEPTH = 8,
  parameter int URGENT_LVL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  output logic              underflow,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [PIX_W-1:0]  cpu_wdata,
  output logic              cpu_rvalid,
  output logic [PIX_W-1:0]  cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  scan_state_t state, state_nx;
  logic [9:0] h;
  logic [8:0] v;
  logic disp_pend, cpu_rd_pend, elig, urgent, cpu_gnt, disp_gnt, last_px, push, pop;
  logic [CW-1:0] count;
  logic [CW:0] fill;
  assign fill = {1'b0, count} + (CW+1)'(disp_pend);
  assign elig = state == SCAN && fill < (CW+1)'(FIFO_DEPTH) && !frame_start;
  assign urgent = elig && fill <= (CW+1)'(URGENT_LVL);
  assign cpu_gnt = cpu_valid && !urgent;
  assign disp_gnt = elig && !cpu_gnt;
  assign cpu_ready = cpu_gnt;
  assign last_px = h == 10'(H_ACTIVE - 1) && v == 9'(V_ACTIVE - 1);
  // a read in flight across frame_start belongs to the old frame and is dropped
  assign push = disp_pend && !frame_start;
  assign pop = pix_req && pix_valid && !frame_start;
  assign underflow = pix_req && !pix_valid && !frame_start;
  assign ram_en = cpu_gnt || disp_gnt;
  assign ram_we = cpu_gnt && cpu_we;
  assign ram_addr = disp_gnt ? {h, v} : cpu_gnt ? cpu_addr : '0;
  assign ram_wdata = ram_we ? cpu_wdata : '0;
  assign cpu_rvalid = cpu_rd_pend;
  assign cpu_rdata = cpu_rd_pend ? ram_rdata : '0;
  always_comb
    state_nx = frame_start ? SCAN : (disp_gnt && last_px) ? DONE : state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      h <= '0;
      v <= '0;
      disp_pend <= 1'b0;
      cpu_rd_pend <= 1'b0;
    end else begin
      state <= state_nx;
      disp_pend <= disp_gnt;
      cpu_rd_pend <= cpu_gnt && !cpu_we;
      if (frame_start) begin
        h <= '0;
        v <= '0;
      end else if (disp_gnt) begin
        h <= h == 10'(H_ACTIVE - 1) ? '0 : h + 1'b1;
        if (h == 10'(H_ACTIVE - 1)) v <= v + 1'b1;
      end
    end
  vga_pix_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(frame_start),
    .din(ram_rdata),
    .valid(pix_valid),
    .dout(pix_data),
    .count(count)
  );
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: vector table, corner sequences and random traffic against a queue-based model
module tb_vga_fb_arbiter;
  localparam int H = 640, V = 8, D = 8, U = 4;
  logic clk = 0, rst = 0, frame_start = 0, pix_req = 0, cpu_valid = 0, cpu_we = 0;
  logic [18:0] cpu_addr = 0;
  logic [23:0] cpu_wdata = 0, ram_rdata = 0;
  logic pix_valid, underflow, cpu_ready, cpu_rvalid, ram_en, ram_we;
  logic [23:0] pix_data, cpu_rdata, ram_wdata;
  logic [18:0] ram_addr;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  vga_fb_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D), .URGENT_LVL(U)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_req(pix_req),
    .pix_valid(pix_valid), .pix_data(pix_data), .underflow(underflow),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );
  // framebuffer: unwritten words read back their own address
  logic [23:0] ram_wr [int];
  logic [23:0] sh [int];
  function automatic logic [23:0] ram_val(input int a);
    return ram_wr.exists(a) ? ram_wr[a] : 24'(a);
  endfunction
  function automatic logic [23:0] sh_val(input int a);
    return sh.exists(a) ? sh[a] : 24'(a);
  endfunction
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) ram_wr[int'(ram_addr)] = ram_wdata;
      else ram_rdata <= ram_val(int'(ram_addr));
    end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  // model: 0 idle, 1 scanning, 2 frame done; m_n is the linear raster index of the next fetch
  int m_st, m_n;
  logic [23:0] q[$];
  bit m_pend, m_rpend;
  logic [23:0] m_pdata, m_rdata;
  logic [18:0] last_ra;
  task automatic model_reset();
    q.delete();
    m_st = 0;
    m_n = 0;
    m_pend = 0;
    m_rpend = 0;
    m_rdata = 0;
  endtask
  task automatic step(input bit fs, input bit req, input bit cv, input bit we,
                      input logic [18:0] a, input logic [23:0] wd);
    int fill;
    bit elig, urg, cg, dg, pv, inc;
    logic [18:0] fa;
    logic [23:0] head;
    @(negedge clk);
    frame_start = fs; pix_req = req; cpu_valid = cv; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    #1;
    fill = q.size() + int'(m_pend);
    elig = m_st == 1 && fill < D && !fs;
    urg = elig && fill <= U;
    cg = cv && !urg;
    dg = elig && !cg;
    inc = m_pend && !fs;
    pv = q.size() > 0 || inc;
    head = q.size() > 0 ? q[0] : inc ? m_pdata : 24'd0;
    fa = 19'(((m_n % H) << 9) | (m_n / H));
    chk("pix_valid", pix_valid, pv);
    chk("pix_data", pix_data, head);
    chk("underflow", underflow, req && !pv && !fs);
    chk("cpu_ready", cpu_ready, cg);
    chk("ram_en", ram_en, cg || dg);
    chk("ram_we", ram_we, cg && we);
    chk("ram_addr", ram_addr, dg ? fa : cg ? a : 19'd0);
    chk("ram_wdata", ram_wdata, (cg && we) ? wd : 24'd0);
    chk("cpu_rvalid", cpu_rvalid, m_rpend);
    chk("cpu_rdata", cpu_rdata, m_rpend ? m_rdata : 24'd0);
    if (dg && m_n == H * V - 1) last_ra = ram_addr;
    if (inc) q.push_back(m_pdata);
    if (req && pv && !fs) void'(q.pop_front());
    if (fs) begin
      q.delete();
      m_st = 1;
      m_n = 0;
    end
    m_rpend = cg && !we;
    m_rdata = sh_val(int'(a));
    if (cg && we) sh[int'(a)] = wd;
    m_pend = dg;
    m_pdata = sh_val(int'(fa));
    if (dg) begin
      if (m_n == H * V - 1) m_st = 2;
      else m_n++;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 0; frame_start = 0; pix_req = 0; cpu_valid = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    #1;
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    @(negedge clk);
    rst = 1;
    model_reset();
  endtask
  typedef struct packed {
    logic fs, req, cv, we;
    logic [18:0] addr;
    logic pv;
    logic [23:0] pd;
    logic uf, cr, en;
    logic [18:0] ra;
    logic rv;
    logic [23:0] rd;
  } vec_t;
  initial begin
    vec_t tbl [10];
    int k;
    bit c;
    ram_wr[32'h12345] = 24'hABCDEF;
    sh[32'h12345] = 24'hABCDEF;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 19'h0,     1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 19'h0,     1'b0, 24'h0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 19'h12345, 1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 19'h12345, 1'b0, 24'h0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 19'h0,     1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 19'h0,     1'b1, 24'hABCDEF};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 19'h0,     1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 19'h0,     1'b0, 24'h0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 19'h0,     1'b0, 24'h0,      1'b0, 1'b0, 1'b1, 19'h0,     1'b0, 24'h0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 19'h0,     1'b1, 24'h0,      1'b0, 1'b0, 1'b1, 19'h200,   1'b0, 24'h0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 19'h5,     1'b1, 24'h0,      1'b0, 1'b0, 1'b1, 19'h400,   1'b0, 24'h0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 19'h0,     1'b1, 24'h200,    1'b0, 1'b0, 1'b1, 19'h600,   1'b0, 24'h0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 19'h7,     1'b1, 24'h400,    1'b0, 1'b0, 1'b1, 19'h800,   1'b0, 24'h0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 19'h0,     1'b1, 24'h600,    1'b0, 1'b0, 1'b1, 19'hA00,   1'b0, 24'h0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      frame_start = tbl[i].fs; pix_req = tbl[i].req; cpu_valid = tbl[i].cv;
      cpu_we = tbl[i].we; cpu_addr = tbl[i].addr; cpu_wdata = 0;
      #1;
      chk($sformatf("t%0d_pix_valid", i), pix_valid, tbl[i].pv);
      chk($sformatf("t%0d_pix_data", i), pix_data, tbl[i].pd);
      chk($sformatf("t%0d_underflow", i), underflow, tbl[i].uf);
      chk($sformatf("t%0d_cpu_ready", i), cpu_ready, tbl[i].cr);
      chk($sformatf("t%0d_ram_en", i), ram_en, tbl[i].en);
      chk($sformatf("t%0d_ram_addr", i), ram_addr, tbl[i].ra);
      chk($sformatf("t%0d_cpu_rvalid", i), cpu_rvalid, tbl[i].rv);
      chk($sformatf("t%0d_cpu_rdata", i), cpu_rdata, tbl[i].rd);
    end
    // frame_start with a display read in flight and a same-cycle pix_req
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("fs_no_underflow", underflow, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("fs_flush_valid", pix_valid, 0);
    chk("fs_restart_addr", ram_addr, 0);
    chk("fs_restart_en", ram_en, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("fs_first_pixel", pix_data, 0);
    // fill to the top, then continuous CPU writes while the display drains slowly
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 24; i++) step(0, i[0], 1, 1, 19'($urandom), 24'($urandom));
    // full frame with no CPU traffic, then CPU-only service in DONE
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    k = 0;
    while (m_st != 2 && k < 6000) begin
      step(0, 1, 0, 0, 0, 0);
      k++;
    end
    chk("frame_bound", k < 6000, 1);
    chk("last_fetch", last_ra, 19'h4FE07);
    for (int i = 0; i < 20; i++) begin
      c = 1'($urandom_range(0, 1));
      step(0, 1, c, 1'($urandom_range(0, 1)), 19'($urandom), 24'($urandom));
      chk("done_en", ram_en, c);
    end
    // reset drops an outstanding CPU read
    step(0, 0, 1, 0, 19'h12345, 0);
    do_reset();
    // random traffic
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40,
           1'($urandom_range(0, 1)), 19'($urandom), 24'($urandom));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
